// File: rtl/coin_pkg.sv
// coin_pkg
//   Shared definitions for the customer-side coin transmitter:
//   - coin bus codes and the value of each coin in units of 5 bani
//   - rest (change) codes seen from the vending machine
//   - the transmitter FSM state encoding
//   - a helper that maps a rest code to its value in units of 5 bani
package coin_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] NOTE_10   = 2'b10;
  localparam logic [1:0] NOTE_50   = 2'b11;

  localparam int UNITS_5  = 1;
  localparam int UNITS_10 = 2;
  localparam int UNITS_50 = 10;

  localparam logic [1:0] REST_NONE = 2'b00;
  localparam logic [1:0] REST_5    = 2'b01;
  localparam logic [1:0] REST_10   = 2'b10;
  localparam logic [1:0] REST_BAD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EMIT  = 3'd1,
    GAP   = 3'd2,
    WATCH = 3'd3,
    DONE  = 3'd4
  } state_t;

  // The machine's rest code 11 is not a legal change value, so it is
  // worth nothing and does not count as a response either.
  function automatic logic [1:0] rest_units(input logic [1:0] rest);
    logic [1:0] units;
    units = 2'd0;
    if (rest == REST_5) begin
      units = 2'd1;
    end else if (rest == REST_10) begin
      units = 2'd2;
    end
    return units;
  endfunction

endpackage

// File: rtl/coin_select.sv
// coin_select
//   Greedy coin choice for the remaining payment.
//   Ports:
//     rem        in   remaining amount, units of 5 bani
//     allow_b50  in   50-bani notes may be used
//     code       out  coin bus code to emit next
//     value      out  value of that coin, units of 5 bani
//   When rem is zero the choice is meaningless; the caller never emits then.
module coin_select
  import coin_pkg::*;
#(
  parameter int AMT_W = 6
) (
  input  logic [AMT_W-1:0] rem,
  input  logic             allow_b50,
  output logic [1:0]       code,
  output logic [AMT_W-1:0] value
);

  logic [31:0] rem_wide;

  assign rem_wide = 32'(rem);

  // Largest coin first: a 50-bani note only when allowed, then a 10-bani
  // note whenever two units remain, otherwise a single 5-bani coin.
  always_comb begin
    code  = COIN_5;
    value = AMT_W'(UNITS_5);
    if (allow_b50 && (rem_wide >= 32'(UNITS_50))) begin
      code  = NOTE_50;
      value = AMT_W'(UNITS_50);
    end else if (rem_wide >= 32'(UNITS_10)) begin
      code  = NOTE_10;
      value = AMT_W'(UNITS_10);
    end
  end

endmodule

// File: rtl/coin_payer.sv
// coin_payer
//   Customer-side coin transmitter for the cola vending machine. A payment
//   is broken greedily into coins, each sent as a one-cycle code on the
//   coin bus followed by GAP_CYCLES idle cycles. Afterwards the machine's
//   cola/rest outputs are watched until RESULT_TIMEOUT quiet cycles pass.
//   Ports:
//     clk           in   clock, rising edge
//     reset         in   synchronous active-high reset
//     start         in   one-cycle request, honoured only when idle
//     amount        in   payment, units of 5 bani, latched on start
//     allow_b50     in   50-bani notes allowed, latched on start
//     bani          out  coin bus code (registered)
//     cola_in       in   machine's cola output
//     rest_in       in   machine's rest output
//     busy          out  transaction in progress
//     done          out  one-cycle completion pulse
//     vend_ok       out  a cola was seen during the transaction
//     change_total  out  change received, units of 5 bani (saturating)
//     timeout       out  no response at all was observed
module coin_payer
  import coin_pkg::*;
#(
  parameter int AMT_W          = 6,
  parameter int GAP_CYCLES     = 4,
  parameter int RESULT_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             allow_b50,
  output logic [1:0]       bani,
  input  logic             cola_in,
  input  logic [1:0]       rest_in,
  output logic             busy,
  output logic             done,
  output logic             vend_ok,
  output logic [AMT_W-1:0] change_total,
  output logic             timeout
);

  state_t           state;
  logic [AMT_W-1:0] rem;
  logic             b50;
  logic [3:0]       gap_cnt;
  logic [7:0]       quiet_cnt;
  logic             seen;

  logic [AMT_W-1:0] sel_rem;
  logic             sel_b50;
  logic [1:0]       sel_code;
  logic [AMT_W-1:0] sel_value;
  logic             activity;
  logic [AMT_W:0]   change_sum;
  logic [AMT_W-1:0] change_next;

  // The coin register is loaded on the edge that enters EMIT, so the code
  // is visible during the EMIT cycle itself. On acceptance the choice is
  // made straight from the incoming amount, later from the remainder.
  always_comb begin
    sel_rem = rem;
    sel_b50 = b50;
    if (state == IDLE) begin
      sel_rem = amount;
      sel_b50 = allow_b50;
    end
  end

  coin_select #(
    .AMT_W(AMT_W)
  ) u_select (
    .rem      (sel_rem),
    .allow_b50(sel_b50),
    .code     (sel_code),
    .value    (sel_value)
  );

  // A response is a cola or a legal change code; the extra top bit of the
  // sum catches overflow so the change total can clamp at all-ones.
  always_comb begin
    activity    = cola_in | (rest_units(rest_in) != 2'd0);
    change_sum  = {1'b0, change_total} + (AMT_W + 1)'(rest_units(rest_in));
    change_next = change_sum[AMT_W-1:0];
    if (change_sum[AMT_W]) begin
      change_next = {AMT_W{1'b1}};
    end
  end

  // Transaction FSM. The remainder is reduced on the same edge that loads
  // the coin, so at GAP expiry a zero remainder means the last coin has
  // already gone out. The machine may answer from the first GAP after the
  // final coin, so observation runs in both GAP and WATCH. The quiet
  // counter ends observation only after RESULT_TIMEOUT silent WATCH cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rem          <= '0;
      b50          <= 1'b0;
      gap_cnt      <= '0;
      quiet_cnt    <= '0;
      seen         <= 1'b0;
      bani         <= COIN_NONE;
      busy         <= 1'b0;
      done         <= 1'b0;
      vend_ok      <= 1'b0;
      change_total <= '0;
      timeout      <= 1'b0;
    end else begin
      bani <= COIN_NONE;
      done <= 1'b0;

      if ((state == GAP) || (state == WATCH)) begin
        if (cola_in) begin
          vend_ok <= 1'b1;
        end
        if (activity) begin
          seen <= 1'b1;
        end
        change_total <= change_next;
      end

      case (state)
        IDLE: begin
          if (start && (amount != '0)) begin
            rem          <= amount - sel_value;
            b50          <= allow_b50;
            bani         <= sel_code;
            busy         <= 1'b1;
            vend_ok      <= 1'b0;
            change_total <= '0;
            timeout      <= 1'b0;
            seen         <= 1'b0;
            state        <= EMIT;
          end
        end

        EMIT: begin
          gap_cnt <= 4'(GAP_CYCLES);
          state   <= GAP;
        end

        GAP: begin
          if (gap_cnt == 4'd1) begin
            gap_cnt <= '0;
            if (rem == '0) begin
              quiet_cnt <= 8'(RESULT_TIMEOUT);
              state     <= WATCH;
            end else begin
              bani  <= sel_code;
              rem   <= rem - sel_value;
              state <= EMIT;
            end
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        WATCH: begin
          if (activity) begin
            quiet_cnt <= 8'(RESULT_TIMEOUT);
          end else if (quiet_cnt == 8'd1) begin
            quiet_cnt <= '0;
            timeout   <= ~seen;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            quiet_cnt <= quiet_cnt - 8'd1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_payer.sv
// tb_coin_payer
//   Scoreboard bench for coin_payer: the stimulus side pushes the expected
//   coin codes and transaction results into queues, and a monitor pops and
//   compares them whenever the design drives a coin or pulses done.
module tb_coin_payer;

  localparam int AMT_W = 6;
  localparam int GAP   = 4;
  localparam int RTO   = 16;

  typedef struct {
    bit       vend;
    bit [5:0] change;
    bit       tmo;
    int       lat;
  } res_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             allow_b50;
  logic [1:0]       bani;
  logic             cola_in;
  logic [1:0]       rest_in;
  logic             busy;
  logic             done;
  logic             vend_ok;
  logic [AMT_W-1:0] change_total;
  logic             timeout;

  logic [1:0] exp_coin[$];
  res_t       exp_res[$];

  int tests_run;
  int tests_failed;
  int cyc;
  int last_coin_cyc;
  bit last_valid;

  coin_payer #(
    .AMT_W(AMT_W),
    .GAP_CYCLES(GAP),
    .RESULT_TIMEOUT(RTO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .amount      (amount),
    .allow_b50   (allow_b50),
    .bani        (bani),
    .cola_in     (cola_in),
    .rest_in     (rest_in),
    .busy        (busy),
    .done        (done),
    .vend_ok     (vend_ok),
    .change_total(change_total),
    .timeout     (timeout)
  );

  // Free-running clock and a cycle counter used for spacing and latency.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: got unexpected event expected none", name);
  endtask

  // Pulse start for one edge, then scramble amount/allow_b50 to show they
  // are not needed after acceptance.
  task automatic applyStimulus(input int amt, input bit b50);
    @(negedge clk);
    amount    = AMT_W'(amt);
    allow_b50 = b50;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    amount    = 6'h2a;
    allow_b50 = ~b50;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (busy && (n < limit)) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) begin
      failNow("wait_idle_timeout");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pushResult(input bit v, input int ch, input bit t, input int lat);
    res_t r;
    r.vend   = v;
    r.change = 6'(ch);
    r.tmo    = t;
    r.lat    = lat;
    exp_res.push_back(r);
  endtask

  // Monitor: sample away from the active edge; every nonzero coin and every
  // done pulse must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (!busy) begin
      last_valid = 1'b0;
    end
    if (bani != 2'b00) begin
      if (exp_coin.size() == 0) begin
        failNow("coin_unexpected");
      end else begin
        checkOutput("coin_code", int'(bani), int'(exp_coin.pop_front()));
      end
      if (last_valid) begin
        checkOutput("coin_spacing", cyc - last_coin_cyc, GAP + 1);
      end
      last_valid    = 1'b1;
      last_coin_cyc = cyc;
    end
    if (done) begin
      if (exp_res.size() == 0) begin
        failNow("done_unexpected");
      end else begin
        res_t r;
        r = exp_res.pop_front();
        checkOutput("vend_ok", int'(vend_ok), int'(r.vend));
        checkOutput("change_total", int'(change_total), int'(r.change));
        checkOutput("timeout", int'(timeout), int'(r.tmo));
        if (r.lat >= 0) begin
          checkOutput("done_latency", cyc - last_coin_cyc, r.lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_valid   = 1'b0;
    last_coin_cyc = 0;
    reset     = 1'b1;
    start     = 1'b0;
    amount    = '0;
    allow_b50 = 1'b0;
    cola_in   = 1'b0;
    rest_in   = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_bani", int'(bani), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_vend", int'(vend_ok), 0);
    checkOutput("reset_change", int'(change_total), 0);
    checkOutput("reset_timeout", int'(timeout), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // 1: amount 3 without 50s, cola in the first WATCH cycle.
    exp_coin.push_back(2'b10);
    exp_coin.push_back(2'b01);
    pushResult(1'b1, 0, 1'b0, 22);
    applyStimulus(3, 1'b0);
    repeat (10) @(posedge clk);
    #1 cola_in = 1'b1;
    @(posedge clk);
    #1 cola_in = 1'b0;
    waitIdle(100);

    // 2: amount 12 with 50s, change 10 then 5, then an illegal rest code.
    exp_coin.push_back(2'b11);
    exp_coin.push_back(2'b10);
    pushResult(1'b0, 3, 1'b0, 23);
    applyStimulus(12, 1'b1);
    repeat (10) @(posedge clk);
    #1 rest_in = 2'b10;
    @(posedge clk);
    #1 rest_in = 2'b01;
    @(posedge clk);
    #1 rest_in = 2'b11;
    @(posedge clk);
    #1 rest_in = 2'b00;
    waitIdle(100);

    // 3: amount 12 without 50s, no response at all.
    for (int i = 0; i < 6; i++) exp_coin.push_back(2'b10);
    pushResult(1'b0, 0, 1'b1, 21);
    applyStimulus(12, 1'b0);
    waitIdle(200);

    // 4: zero amount is ignored, then a single 5-bani coin.
    applyStimulus(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("zero_busy", int'(busy), 0);
    checkOutput("zero_bani", int'(bani), 0);
    exp_coin.push_back(2'b01);
    pushResult(1'b0, 0, 1'b1, 21);
    applyStimulus(1, 1'b0);
    waitIdle(100);

    // 5: start pulses while busy must not disturb a 3-unit payment.
    exp_coin.push_back(2'b10);
    exp_coin.push_back(2'b01);
    pushResult(1'b0, 0, 1'b1, 21);
    applyStimulus(3, 1'b0);
    #1 begin start = 1'b1; amount = 6'd20; allow_b50 = 1'b1; end
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 begin start = 1'b1; amount = 6'd20; allow_b50 = 1'b1; end
    @(posedge clk);
    #1 start = 1'b0;
    waitIdle(100);

    // 6: reset in the first GAP abandons the transaction.
    exp_coin.push_back(2'b10);
    applyStimulus(12, 1'b0);
    @(posedge clk);
    #1 begin cola_in = 1'b1; rest_in = 2'b10; end
    @(posedge clk);
    #1 begin cola_in = 1'b0; rest_in = 2'b00; end
    checkOutput("pre_reset_vend", int'(vend_ok), 1);
    checkOutput("pre_reset_change", int'(change_total), 2);
    checkOutput("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_reset_bani", int'(bani), 0);
    checkOutput("mid_reset_busy", int'(busy), 0);
    checkOutput("mid_reset_vend", int'(vend_ok), 0);
    checkOutput("mid_reset_change", int'(change_total), 0);
    checkOutput("mid_reset_done", int'(done), 0);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    exp_coin.push_back(2'b10);
    pushResult(1'b0, 0, 1'b1, 21);
    applyStimulus(2, 1'b0);
    waitIdle(100);

    // 7: sustained 10-bani change saturates at 63; code 11 adds nothing.
    exp_coin.push_back(2'b01);
    pushResult(1'b0, 63, 1'b0, -1);
    applyStimulus(1, 1'b0);
    #1 rest_in = 2'b10;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("sat_change", int'(change_total), 63);
    rest_in = 2'b11;
    repeat (3) @(posedge clk);
    #1 rest_in = 2'b00;
    waitIdle(100);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("coins_left", exp_coin.size(), 0);
    checkOutput("results_left", exp_res.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
